// File: rtl/mont_r2_gen.sv
// mont_r2_gen
//   Builds the Montgomery constant R2 = 2^(2k) mod N, where k = N_LEN+1 is
//   the bit length of N. Starting from x = 1, each clock does one doubling
//   followed by a conditional subtract of N. After 2k steps x holds R2.
//
// Ports
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   start   one-cycle request, accepted in IDLE or DONE
//   N       modulus (odd, >= 3), sampled on the accepted start edge
//   N_LEN   index of N's most significant set bit, sampled with N
//   R2      result, valid while finish = 1
//   busy    high while iterating
//   finish  level, high from completion until next accepted start or reset
//   err     high together with finish when the captured N was invalid
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | one double/reduce step per clock, cnt_q steps left
// DONE  | result held; start launches a new computation
module mont_r2_gen #(
  parameter int WIDTH = 2048,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [LEN_W-1:0] N_LEN,
  output logic [WIDTH-1:0] R2,
  output logic             busy,
  output logic             finish,
  output logic             err
);

  localparam int CNT_W = LEN_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] x_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] r2_q;
  logic             busy_q;
  logic             finish_q;
  logic             err_q;

  logic [WIDTH-1:0] t_lo;
  logic             t_ge_n;
  logic [WIDTH-1:0] x_d;
  logic [CNT_W-1:0] cnt_d;
  logic             n_bad;

  // t = 2x has WIDTH+1 bits: x_q[WIDTH-1] is its carry-out bit. With that
  // carry set, t already exceeds any WIDTH-bit n_q; otherwise compare the low
  // bits. Since x < n_q the true difference fits in WIDTH bits, so the
  // modulo-2^WIDTH subtraction of the low bits is exact.
  always_comb begin
    t_lo   = {x_q[WIDTH-2:0], 1'b0};
    t_ge_n = x_q[WIDTH-1] | (t_lo >= n_q);
    x_d    = t_ge_n ? (t_lo - n_q) : t_lo;
  end

  // Step count 2k = 2*(N_LEN+1); the extra counter bit keeps 2*WIDTH exact.
  always_comb begin
    cnt_d = {({1'b0, N_LEN} + (LEN_W+1)'(1)), 1'b0};
    n_bad = ~N[0] | (N < WIDTH'(3));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      x_q      <= '0;
      cnt_q    <= '0;
      r2_q     <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            n_q      <= N;
            cnt_q    <= cnt_d;
            finish_q <= 1'b0;
            err_q    <= 1'b0;
            if (n_bad) begin
              // Reject at once: no iteration, result forced to zero.
              r2_q     <= '0;
              finish_q <= 1'b1;
              err_q    <= 1'b1;
              state_q  <= DONE;
            end else begin
              x_q     <= WIDTH'(1);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          x_q   <= x_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            r2_q     <= x_d;
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign R2     = r2_q;
  assign busy   = busy_q;
  assign finish = finish_q;
  assign err    = err_q;

endmodule
